// File: rtl/fetch_queue.sv
// fetch_queue: IF/ID stage buffer. A DEPTH-entry FIFO of {pc, instruction}
// pairs absorbs fetch words while decode is stalled. A registered output
// stage drives decode. A taken branch empties the queue and issues a train
// of 1+FLUSH_BUBBLES bubbles.
module fetch_queue #(
  parameter int                XLEN          = 32,
  parameter int                DEPTH         = 4,
  parameter int                FLUSH_BUBBLES = 2,
  parameter logic [XLEN-1:0]   BUBBLE_INSN   = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [XLEN-1:0]            pc_if,
  input  logic [XLEN-1:0]            instruction_if,
  output logic                       in_ready,
  input  logic                       hold,
  input  logic                       if_flush,
  output logic                       out_valid,
  output logic [XLEN-1:0]            pc_id,
  output logic [XLEN-1:0]            instruction_id,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int BW = 4;
  localparam logic [CW-1:0] FULL    = CW'(DEPTH);
  localparam logic [BW-1:0] BUB_LEN = BW'(FLUSH_BUBBLES);

  // Each entry is packed as {pc, instruction}.
  logic [2*XLEN-1:0] mem_q [DEPTH];
  logic [2*XLEN-1:0] mem_d [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [BW-1:0]     bub_cnt_q, bub_cnt_d;
  logic              out_valid_q, out_valid_d;
  logic [XLEN-1:0]   pc_id_q, pc_id_d;
  logic [XLEN-1:0]   insn_id_q, insn_id_d;
  logic              push, pop;
  logic              in_ready_c;

  // During the bubble phase inputs are sunk, so the queue always reports ready.
  assign in_ready_c = (bub_cnt_q != '0) || (count_q != FULL);

  // Next-state: flush beats bubble phase, which beats hold, which beats normal flow.
  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    bub_cnt_d   = bub_cnt_q;
    out_valid_d = out_valid_q;
    pc_id_d     = pc_id_q;
    insn_id_d   = insn_id_q;
    push        = 1'b0;
    pop         = 1'b0;

    if (if_flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      bub_cnt_d   = BUB_LEN;
      out_valid_d = 1'b0;
      pc_id_d     = pc_if;
      insn_id_d   = BUBBLE_INSN;
    end else if (bub_cnt_q != '0) begin
      // A stalled decode freezes the bubble train so no bubble is skipped.
      if (!hold) begin
        bub_cnt_d   = bub_cnt_q - BW'(1);
        out_valid_d = 1'b0;
        pc_id_d     = pc_if;
        insn_id_d   = BUBBLE_INSN;
      end
    end else if (hold) begin
      push = in_valid && (count_q != FULL);
    end else begin
      if (count_q != '0) begin
        pop                    = 1'b1;
        {pc_id_d, insn_id_d}   = mem_q[rd_ptr_q];
        out_valid_d            = 1'b1;
        // Full blocks the push, so push and pop never coincide on a full queue.
        push                   = in_valid && (count_q != FULL);
      end else if (in_valid) begin
        pc_id_d     = pc_if;
        insn_id_d   = instruction_if;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
        insn_id_d   = BUBBLE_INSN;
      end
    end

    if (push) begin
      mem_d[wr_ptr_q] = {pc_if, instruction_if};
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
  end

  // State registers; reset clears every entry so nothing survives a mid-queue reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q       <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      bub_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      pc_id_q     <= '0;
      insn_id_q   <= BUBBLE_INSN;
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      bub_cnt_q   <= bub_cnt_d;
      out_valid_q <= out_valid_d;
      pc_id_q     <= pc_id_d;
      insn_id_q   <= insn_id_d;
    end
  end

  assign in_ready       = in_ready_c;
  assign out_valid      = out_valid_q;
  assign pc_id          = pc_id_q;
  assign instruction_id = insn_id_q;
  assign count          = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed scenarios plus randomized traffic. Every output is
// compared against a queue-based behavioural model of the IF/ID buffer.
module tb_fetch_queue;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam int FB    = 2;
  localparam logic [XLEN-1:0] BUB = 32'h0;
  localparam int CW    = $clog2(DEPTH + 1);

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic [XLEN-1:0] pc_if;
  logic [XLEN-1:0] instruction_if;
  logic            in_ready;
  logic            hold;
  logic            if_flush;
  logic            out_valid;
  logic [XLEN-1:0] pc_id;
  logic [XLEN-1:0] instruction_id;
  logic [CW-1:0]   count;

  fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .FLUSH_BUBBLES(FB), .BUBBLE_INSN(BUB)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .pc_if(pc_if),
    .instruction_if(instruction_if), .in_ready(in_ready), .hold(hold),
    .if_flush(if_flush), .out_valid(out_valid), .pc_id(pc_id),
    .instruction_id(instruction_id), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] insn;
  } ent_t;

  // Behavioural model state
  ent_t            m_q[$];
  int              m_bub;
  logic            m_ov;
  logic [XLEN-1:0] m_pc;
  logic [XLEN-1:0] m_insn;

  int n_vec = 0;
  int n_err = 0;
  logic [XLEN-1:0] next_pc = 32'h100;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic m_ready();
    return (m_bub != 0) || (m_q.size() != DEPTH);
  endfunction

  task automatic m_reset();
    m_q.delete();
    m_bub  = 0;
    m_ov   = 1'b0;
    m_pc   = '0;
    m_insn = BUB;
  endtask

  task automatic m_clock(input logic iv, input logic [XLEN-1:0] pc, input logic [XLEN-1:0] ins,
                         input logic hd, input logic fl);
    ent_t e;
    int   sz;
    sz = m_q.size();
    if (fl) begin
      m_q.delete();
      m_ov = 1'b0; m_insn = BUB; m_pc = pc; m_bub = FB;
    end else if (m_bub > 0) begin
      if (!hd) begin
        m_ov = 1'b0; m_insn = BUB; m_pc = pc; m_bub = m_bub - 1;
      end
    end else if (hd) begin
      if (iv && sz < DEPTH) m_q.push_back('{pc: pc, insn: ins});
    end else if (sz > 0) begin
      e = m_q.pop_front();
      m_pc = e.pc; m_insn = e.insn; m_ov = 1'b1;
      if (iv && sz != DEPTH) m_q.push_back('{pc: pc, insn: ins});
    end else if (iv) begin
      m_pc = pc; m_insn = ins; m_ov = 1'b1;
    end else begin
      m_ov = 1'b0; m_insn = BUB;
    end
  endtask

  task automatic check_outputs();
    check("out_valid", 64'(out_valid), 64'(m_ov));
    check("pc_id", 64'(pc_id), 64'(m_pc));
    check("instruction_id", 64'(instruction_id), 64'(m_insn));
    check("count", 64'(count), 64'(m_q.size()));
  endtask

  // One clock of stimulus: drive after negedge, check in_ready, clock, check registers.
  task automatic step(input logic iv, input logic [XLEN-1:0] pc, input logic [XLEN-1:0] ins,
                      input logic hd, input logic fl);
    @(negedge clk);
    in_valid = iv; pc_if = pc; instruction_if = ins; hold = hd; if_flush = fl;
    #1;
    check("in_ready", 64'(in_ready), 64'(m_ready()));
    @(posedge clk);
    m_clock(iv, pc, ins, hd, fl);
    #1;
    check_outputs();
  endtask

  // Fetch the next sequential word; pc only advances when the word is taken.
  task automatic fetch(input logic hd, input logic fl);
    logic acc;
    acc = m_ready();
    step(1'b1, next_pc, $urandom, hd, fl);
    if (acc) next_pc = next_pc + 4;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; pc_if = '0; instruction_if = '0; hold = 1'b0; if_flush = 1'b0;
    m_reset();
    #12;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_pc_id", 64'(pc_id), 64'(0));
    check("rst_instruction_id", 64'(instruction_id), 64'(BUB));
    check("rst_count", 64'(count), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));
    @(negedge clk);
    rst = 1'b0;

    // Streaming with bypass: pc_id trails pc_if by one cycle, count stays 0.
    for (int i = 0; i < 6; i++) step(1'b1, 32'(i * 4), $urandom, 1'b0, 1'b0);
    check("stream_pc", 64'(pc_id), 64'(20));

    // Hold for three fetches, then drain in order followed by bypass.
    step(1'b1, 32'h10, 32'hA0, 1'b1, 1'b0);
    step(1'b1, 32'h14, 32'hA1, 1'b1, 1'b0);
    step(1'b1, 32'h18, 32'hA2, 1'b1, 1'b0);
    check("hold_count3", 64'(count), 64'(3));
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    check("drain_first", 64'(pc_id), 64'(32'h10));
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    step(1'b1, 32'h1C, 32'hA3, 1'b0, 1'b0);
    check("bypass_after_drain", 64'(pc_id), 64'(32'h1C));

    // Overfill while held: words 5 and 6 are refused.
    for (int i = 0; i < DEPTH + 2; i++) step(1'b1, 32'(32'h200 + i * 4), $urandom, 1'b1, 1'b0);
    check("full_count", 64'(count), 64'(DEPTH));
    check("full_in_ready", 64'(in_ready), 64'(0));
    for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Flush with two entries queued, then three bubbles, then first post-flush fetch.
    step(1'b1, 32'h300, 32'hB0, 1'b1, 1'b0);
    step(1'b1, 32'h304, 32'hB1, 1'b1, 1'b0);
    step(1'b1, 32'h400, 32'hC0, 1'b0, 1'b1);
    check("flush_count", 64'(count), 64'(0));
    step(1'b1, 32'h404, 32'hC1, 1'b0, 1'b0);
    step(1'b1, 32'h408, 32'hC2, 1'b0, 1'b0);
    check("bubble_valid", 64'(out_valid), 64'(0));
    step(1'b1, 32'h40C, 32'hC3, 1'b0, 1'b0);
    check("post_flush_pc", 64'(pc_id), 64'(32'h40C));

    // Flush and hold together, hold during bubbles: train is frozen, not shortened.
    step(1'b1, 32'h500, 32'hD0, 1'b1, 1'b1);
    step(1'b1, 32'h504, 32'hD1, 1'b1, 1'b0);
    step(1'b1, 32'h508, 32'hD2, 1'b1, 1'b0);
    check("bubble_frozen_count", 64'(count), 64'(0));
    step(1'b1, 32'h50C, 32'hD3, 1'b0, 1'b0);
    step(1'b1, 32'h510, 32'hD4, 1'b0, 1'b0);
    step(1'b1, 32'h514, 32'hD5, 1'b0, 1'b0);
    check("after_frozen_bubbles", 64'(out_valid), 64'(1));

    // Asynchronous reset with three words queued.
    for (int i = 0; i < 3; i++) step(1'b1, 32'(32'h600 + i * 4), $urandom, 1'b1, 1'b0);
    @(negedge clk);
    in_valid = 1'b0; hold = 1'b0; if_flush = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("arst_count", 64'(count), 64'(0));
    check("arst_out_valid", 64'(out_valid), 64'(0));
    check("arst_pc_id", 64'(pc_id), 64'(0));
    check("arst_instruction_id", 64'(instruction_id), 64'(BUB));
    m_reset();
    @(negedge clk);
    rst = 1'b0;

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      logic hd, fl, iv;
      hd = ($urandom_range(0, 99) < 35);
      fl = ($urandom_range(0, 99) < 4);
      iv = ($urandom_range(0, 99) < 75);
      if (iv) fetch(hd, fl);
      else    step(1'b0, $urandom, $urandom, hd, fl);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
